oam_dma: RTL and testbench

OAM DMA engine triggered by a CPU write to $4014. It halts the 6502 and copies one 256-byte page, $XX00–$XXFF, over the CPU bus to the PPU OAM data port $2004. When XX is $00–$1F, the source is the 2 KB system RAM, with mirroring resolved by the bus decoder. The block sits beside the CPU as a bus master, directly upstream of the system RAM read port and the PPU register write port.

---
 rtl/oam_dma.sv | 171 +++++++++++++++++
 tb/tb_oam_dma.sv | 332 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/oam_dma.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module   : oam_dma
//  Purpose  : OAM DMA engine. A CPU write to $4014 halts the CPU and copies
//             the 256-byte page $XX00-$XXFF to the PPU OAM data port $2004,
//             one read cycle followed by one write cycle per byte. Reads are
//             aligned so that every READ falls on an even CPU cycle.
//  Ports    : clk          - system clock
//             reset        - asynchronous, active-low reset
//             cpu_ce       - one-clk strobe at the end of each CPU cycle
//             reg_wr       - CPU write to $4014 (qualified by cpu_ce)
//             reg_data     - page number written to $4014
//             bus_data_in  - read data returned by the bus (1-clk latency)
//             bus_addr     - DMA bus address
//             bus_rden     - DMA read request
//             bus_wren     - DMA write request
//             bus_data_out - DMA write data
//             cpu_halt     - stalls the CPU while the DMA owns the bus
//             dma_active   - high while a transfer is in progress
//             dma_done     - one-clk pulse on completion
//  Revision : 1.0 - initial release
// ============================================================================
module oam_dma (
  input  logic        clk,
  input  logic        reset,
  input  logic        cpu_ce,
  input  logic        reg_wr,
  input  logic [7:0]  reg_data,
  input  logic [7:0]  bus_data_in,
  output logic [15:0] bus_addr,
  output logic        bus_rden,
  output logic        bus_wren,
  output logic [7:0]  bus_data_out,
  output logic        cpu_halt,
  output logic        dma_active,
  output logic        dma_done
);

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_HALT  = 3'd1,
    ST_ALIGN = 3'd2,
    ST_READ  = 3'd3,
    ST_WRITE = 3'd4
  } state_t;

  localparam logic [15:0] C_OAM_DATA_ADDR = 16'h2004;

  state_t     r_state;
  state_t     w_state_nxt;
  logic [7:0] r_page;
  logic [7:0] w_page_nxt;
  logic [7:0] r_idx;
  logic [7:0] w_idx_nxt;
  logic [7:0] r_latch;
  logic [7:0] w_latch_nxt;
  logic       r_cpu_odd;
  logic       w_done_evt;
  logic       r_done_evt;

  // --------------------------------------------------------------------------
  // State and datapath registers; they only advance at the end of a CPU cycle.
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state   <= ST_IDLE;
      r_page    <= 8'h00;
      r_idx     <= 8'h00;
      r_latch   <= 8'h00;
      r_cpu_odd <= 1'b0;
    end else if (cpu_ce) begin
      r_state   <= w_state_nxt;
      r_page    <= w_page_nxt;
      r_idx     <= w_idx_nxt;
      r_latch   <= w_latch_nxt;
      r_cpu_odd <= ~r_cpu_odd;
    end
  end

  // --------------------------------------------------------------------------
  // Next-state logic. Only consumed by the register block when cpu_ce=1.
  // --------------------------------------------------------------------------
  always_comb begin
    w_state_nxt = r_state;
    w_page_nxt  = r_page;
    w_idx_nxt   = r_idx;
    w_latch_nxt = r_latch;
    w_done_evt  = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (reg_wr) begin
          w_page_nxt  = reg_data;
          w_idx_nxt   = 8'h00;
          w_state_nxt = ST_HALT;
        end
      end
      ST_HALT: begin
        // r_cpu_odd is the parity of the HALT cycle itself; an even HALT
        // would make the following cycle odd, so insert one ALIGN cycle.
        w_state_nxt = r_cpu_odd ? ST_READ : ST_ALIGN;
      end
      ST_ALIGN: begin
        w_state_nxt = ST_READ;
      end
      ST_READ: begin
        w_latch_nxt = bus_data_in;
        w_state_nxt = ST_WRITE;
      end
      ST_WRITE: begin
        if (r_idx == 8'hFF) begin
          w_state_nxt = ST_IDLE;
          w_done_evt  = 1'b1;
        end else begin
          w_idx_nxt   = r_idx + 8'd1;
          w_state_nxt = ST_READ;
        end
      end
      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase
  end

  // Completion marker, high only for the clk of the final cpu_ce edge.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_done_evt <= 1'b0;
    end else begin
      r_done_evt <= cpu_ce & w_done_evt;
    end
  end

  // --------------------------------------------------------------------------
  // Registered outputs: follow the state one clk after the cpu_ce edge that
  // moved it, and hold for the whole CPU cycle.
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      bus_addr     <= 16'h0000;
      bus_rden     <= 1'b0;
      bus_wren     <= 1'b0;
      bus_data_out <= 8'h00;
      cpu_halt     <= 1'b0;
      dma_active   <= 1'b0;
      dma_done     <= 1'b0;
    end else begin
      bus_rden     <= (r_state == ST_READ);
      bus_wren     <= (r_state == ST_WRITE);
      cpu_halt     <= (r_state != ST_IDLE);
      dma_active   <= (r_state != ST_IDLE);
      dma_done     <= r_done_evt;
      case (r_state)
        ST_READ: begin
          bus_addr     <= {r_page, r_idx};
          bus_data_out <= 8'h00;
        end
        ST_WRITE: begin
          bus_addr     <= C_OAM_DATA_ADDR;
          bus_data_out <= r_latch;
        end
        default: begin
          bus_addr     <= 16'h0000;
          bus_data_out <= 8'h00;
        end
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_oam_dma.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module   : tb_oam_dma
//  Purpose  : Self-checking bench for oam_dma. A cycle-count model of the
//             transfer predicts every output on every clk; directed scenarios
//             add literal checks on cycle counts, addresses and data order.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_oam_dma;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        cpu_ce = 1'b0;
  logic        reg_wr = 1'b0;
  logic [7:0]  reg_data = 8'h00;
  logic [7:0]  bus_data_in;
  logic [15:0] bus_addr;
  logic        bus_rden;
  logic        bus_wren;
  logic [7:0]  bus_data_out;
  logic        cpu_halt;
  logic        dma_active;
  logic        dma_done;

  oam_dma dut (
    .clk          (clk),
    .reset        (reset),
    .cpu_ce       (cpu_ce),
    .reg_wr       (reg_wr),
    .reg_data     (reg_data),
    .bus_data_in  (bus_data_in),
    .bus_addr     (bus_addr),
    .bus_rden     (bus_rden),
    .bus_wren     (bus_wren),
    .bus_data_out (bus_data_out),
    .cpu_halt     (cpu_halt),
    .dma_active   (dma_active),
    .dma_done     (dma_done)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  // Memory behind the bus; 1-clk registered read latency, junk when idle.
  logic [7:0] mem [0:65535];
  always @(posedge clk) begin
    bus_data_in <= bus_rden ? mem[bus_addr] : 8'hEE;
  end

  // --------------------------------------------------------------------------
  // Transfer model: counts CPU cycles since the trigger and derives the bus
  // activity of each cycle arithmetically.
  // --------------------------------------------------------------------------
  logic       m_active, m_align, m_parity, m_done;
  logic [9:0] m_cyc;
  logic [7:0] m_page;
  logic       n_active, n_align, n_parity, n_done;
  logic [9:0] n_cyc;
  logic [7:0] n_page;

  always @* begin
    n_active = m_active;
    n_align  = m_align;
    n_parity = m_parity;
    n_cyc    = m_cyc;
    n_page   = m_page;
    n_done   = 1'b0;
    if (cpu_ce) begin
      n_parity = ~m_parity;
      if (!m_active) begin
        if (reg_wr) begin
          n_active = 1'b1;
          n_cyc    = 10'd0;
          n_page   = reg_data;
          n_align  = (n_parity == 1'b0);
        end
      end else begin
        n_cyc = m_cyc + 10'd1;
        if (n_cyc == (m_align ? 10'd514 : 10'd513)) begin
          n_active = 1'b0;
          n_done   = 1'b1;
        end
      end
    end
  end

  logic [15:0] e_addr;
  logic        e_rden, e_wren;
  logic [7:0]  e_dout;
  logic [9:0]  e_k;
  always @* begin
    e_addr = 16'h0000;
    e_rden = 1'b0;
    e_wren = 1'b0;
    e_dout = 8'h00;
    e_k    = 10'd0;
    if (m_active && (m_cyc >= (m_align ? 10'd2 : 10'd1))) begin
      e_k = m_cyc - (m_align ? 10'd2 : 10'd1);
      if (!e_k[0]) begin
        e_rden = 1'b1;
        e_addr = {m_page, e_k[8:1]};
      end else begin
        e_wren = 1'b1;
        e_addr = 16'h2004;
        e_dout = mem[{m_page, e_k[8:1]}];
      end
    end
  end

  logic [15:0] x_addr;
  logic        x_rden, x_wren, x_halt, x_done;
  logic [7:0]  x_dout;
  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      m_active <= 1'b0; m_align <= 1'b0; m_parity <= 1'b0; m_done <= 1'b0;
      m_cyc <= 10'd0; m_page <= 8'h00;
      x_addr <= 16'h0000; x_rden <= 1'b0; x_wren <= 1'b0;
      x_halt <= 1'b0; x_done <= 1'b0; x_dout <= 8'h00;
    end else begin
      x_addr <= e_addr; x_rden <= e_rden; x_wren <= e_wren;
      x_dout <= e_dout; x_halt <= m_active; x_done <= m_done;
      m_active <= n_active; m_align <= n_align; m_parity <= n_parity;
      m_cyc <= n_cyc; m_page <= n_page; m_done <= n_done;
    end
  end

  // Per-clk comparison of every output against the model.
  always @(negedge clk) begin
    checks <= checks + 1;
    if ({bus_addr, bus_rden, bus_wren, bus_data_out, cpu_halt, dma_active, dma_done} !==
        {x_addr, x_rden, x_wren, x_dout, x_halt, x_halt, x_done}) begin
      failures <= failures + 1;
      if (failures < 20)
        $display("FAIL cycle_compare t=%0t got addr=%h rd=%b wr=%b d=%h halt=%b act=%b done=%b want addr=%h rd=%b wr=%b d=%h halt=%b act=%b done=%b",
                 $time, bus_addr, bus_rden, bus_wren, bus_data_out, cpu_halt, dma_active, dma_done,
                 x_addr, x_rden, x_wren, x_dout, x_halt, x_halt, x_done);
    end
  end

  // --------------------------------------------------------------------------
  // Observation of the DUT for the directed literal checks.
  // --------------------------------------------------------------------------
  int halt_cnt = 0;
  int done_cnt = 0;
  int bad_runs = 0;
  int rd_run = 0;
  logic [15:0] rd_q[$];
  logic [7:0]  wr_q[$];
  int run_q[$];
  always @(negedge clk) begin
    if (cpu_ce && cpu_halt) halt_cnt <= halt_cnt + 1;
    if (cpu_ce && bus_rden) rd_q.push_back(bus_addr);
    if (cpu_ce && bus_wren) wr_q.push_back(bus_data_out);
    if (dma_done) done_cnt <= done_cnt + 1;
    if (bus_rden) rd_run <= rd_run + 1;
    else if (rd_run != 0) begin
      run_q.push_back(rd_run);
      rd_run <= 0;
    end
  end

  // --------------------------------------------------------------------------
  // cpu_ce generator; also issues requested $4014 writes on a cpu_ce whose
  // edge gives the requested HALT-cycle parity.
  // --------------------------------------------------------------------------
  int         ce_period = 3;
  int         ce_cnt = 0;
  logic       req_pend = 1'b0;
  logic       req_any = 1'b0;
  logic       req_par = 1'b0;
  logic [7:0] req_data = 8'h00;

  initial begin
    forever begin
      @(posedge clk);
      #2;
      if (ce_cnt >= ce_period - 1) begin
        ce_cnt = 0;
        cpu_ce = 1'b1;
        if (req_pend && (req_any || ((~m_parity) == req_par))) begin
          reg_wr   = 1'b1;
          reg_data = req_data;
          req_pend = 1'b0;
        end else begin
          reg_wr = 1'b0;
        end
      end else begin
        ce_cnt = ce_cnt + 1;
        cpu_ce = 1'b0;
        reg_wr = 1'b0;
      end
    end
  end

  int s_halt, s_done, s_rd, s_wr, s_run;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
    checks = checks + 1;
    if (got !== want) begin
      failures = failures + 1;
      $display("FAIL %s got=%0h want=%0h t=%0t", name, got, want, $time);
    end
  endtask

  task automatic wait_req();
    int n = 0;
    while (req_pend && n < 200) begin
      @(posedge clk);
      n++;
    end
    check("trigger_issued", {31'd0, req_pend}, 32'd0);
    req_pend = 1'b0;
  endtask

  task automatic start_xfer(input logic [7:0] pg, input logic par);
    s_halt = halt_cnt; s_done = done_cnt;
    s_rd = rd_q.size(); s_wr = wr_q.size(); s_run = run_q.size();
    req_data = pg; req_par = par; req_any = 1'b0; req_pend = 1'b1;
    wait_req();
  endtask

  task automatic finish_xfer(input int exp_cyc, input logic [7:0] pg);
    int n = 0;
    while (done_cnt == s_done && n < 520 * ce_period + 100) begin
      @(negedge clk);
      n++;
    end
    repeat (4) @(negedge clk);
    check("cycles", halt_cnt - s_halt, exp_cyc);
    check("done_pulses", done_cnt - s_done, 1);
    check("reads", rd_q.size() - s_rd, 256);
    check("writes", wr_q.size() - s_wr, 256);
    check("idle_after", {31'd0, dma_active}, 32'd0);
    if (rd_q.size() >= s_rd + 256) begin
      check("first_rd", {16'd0, rd_q[s_rd]}, {16'd0, pg, 8'h00});
      check("last_rd", {16'd0, rd_q[s_rd + 255]}, {16'd0, pg, 8'hFF});
    end
  endtask

  task automatic check_page3_data();
    if (wr_q.size() >= s_wr + 256) begin
      for (int i = 0; i < 256; i++)
        check("page3_data", {24'd0, wr_q[s_wr + i]}, {24'd0, 8'(i) ^ 8'hA5});
    end
  endtask

  task automatic wait_cond_rd(input logic [15:0] a);
    int n = 0;
    while (!(bus_rden && bus_addr == a) && n < 5000) begin
      @(negedge clk);
      n++;
    end
    check("reach_read", {31'd0, bus_rden && bus_addr == a}, 32'd1);
  endtask

  // --------------------------------------------------------------------------
  // Directed scenarios
  // --------------------------------------------------------------------------
  initial begin
    for (int i = 0; i < 65536; i++) begin
      logic [15:0] a;
      a = 16'(i);
      mem[i] = a[7:0] ^ a[15:8] ^ 8'h3C;
    end
    for (int i = 0; i < 256; i++) mem[16'h0300 + i] = 8'(i) ^ 8'hA5;

    // Reset state
    repeat (4) @(negedge clk);
    check("rst_addr", {16'd0, bus_addr}, 32'd0);
    check("rst_flags", {25'd0, bus_rden, bus_wren, cpu_halt, dma_active, dma_done, 2'b00}, 32'd0);
    check("rst_dout", {24'd0, bus_data_out}, 32'd0);
    @(posedge clk); #3 reset = 1'b1;
    repeat (10) @(negedge clk);

    // No ALIGN: HALT cycle odd
    start_xfer(8'h02, 1'b1);
    finish_xfer(513, 8'h02);

    // ALIGN inserted: HALT cycle even
    start_xfer(8'h02, 1'b0);
    finish_xfer(514, 8'h02);

    // Data integrity, page 3
    start_xfer(8'h03, 1'b1);
    finish_xfer(513, 8'h03);
    check_page3_data();

    // Retrigger during pair 100 is ignored
    start_xfer(8'h02, 1'b1);
    wait_cond_rd(16'h0264);
    req_data = 8'h07; req_any = 1'b1; req_pend = 1'b1;
    wait_req();
    finish_xfer(513, 8'h02);
    check("retrig_rd101", {16'd0, rd_q[s_rd + 101]}, 32'h0000_0265);

    // Reset in the WRITE cycle of idx $40
    start_xfer(8'h02, 1'b0);
    wait_cond_rd(16'h0240);
    while (!bus_wren) @(negedge clk);
    #1 reset = 1'b0;
    #1;
    check("rst_mid_halt", {31'd0, cpu_halt}, 32'd0);
    check("rst_mid_wren", {31'd0, bus_wren}, 32'd0);
    check("rst_mid_active", {31'd0, dma_active}, 32'd0);
    repeat (20) @(negedge clk);
    check("rst_mid_nodone", done_cnt - s_done, 0);
    @(posedge clk); #3 reset = 1'b1;
    repeat (5) @(negedge clk);
    start_xfer(8'h02, 1'b1);
    finish_xfer(513, 8'h02);

    // Slow cpu_ce, period 12 clk
    ce_period = 12;
    repeat (30) @(negedge clk);
    start_xfer(8'h03, 1'b0);
    finish_xfer(514, 8'h03);
    check_page3_data();
    bad_runs = 0;
    for (int i = s_run; i < run_q.size(); i++)
      if (run_q[i] != 12) bad_runs++;
    check("slow_rd_runs", run_q.size() - s_run, 256);
    check("slow_rd_len", bad_runs, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
